// File: rtl/alu_mdu_seq_pkg.sv
// Shared op-code constants and decode helpers for the execute ALU / multiply-divide unit.
package alu_mdu_seq_pkg;

    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_SUB    = 5'd1;
    localparam logic [4:0] OP_SLL    = 5'd2;
    localparam logic [4:0] OP_SLT    = 5'd3;
    localparam logic [4:0] OP_SLTU   = 5'd4;
    localparam logic [4:0] OP_XOR    = 5'd5;
    localparam logic [4:0] OP_SRL    = 5'd6;
    localparam logic [4:0] OP_SRA    = 5'd7;
    localparam logic [4:0] OP_OR     = 5'd8;
    localparam logic [4:0] OP_AND    = 5'd9;
    localparam logic [4:0] OP_MUL    = 5'd16;
    localparam logic [4:0] OP_MULH   = 5'd17;
    localparam logic [4:0] OP_MULHSU = 5'd18;
    localparam logic [4:0] OP_MULHU  = 5'd19;
    localparam logic [4:0] OP_DIV    = 5'd20;
    localparam logic [4:0] OP_DIVU   = 5'd21;
    localparam logic [4:0] OP_REM    = 5'd22;
    localparam logic [4:0] OP_REMU   = 5'd23;

    function automatic logic is_mul(input logic [4:0] op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
    endfunction

    function automatic logic is_div(input logic [4:0] op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic is_muldiv(input logic [4:0] op);
        return is_mul(op) || is_div(op);
    endfunction

endpackage

// File: rtl/alu_mdu_seq_mdu_iter.sv
// Iterative radix-2 datapath: shift-add multiply and restoring divide on unsigned magnitudes.
module mdu_iter
    import alu_mdu_seq_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);
    localparam int unsigned CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] CNT_END = CW'(XLEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

    logic [XLEN-1:0] r_hi, r_lo, r_b;
    logic [CW-1:0]   r_cnt;
    logic            r_is_div;

    logic            w_run;
    logic            w_carry;
    logic [XLEN-1:0] w_sum;
    logic [XLEN:0]   w_rem_sh;
    logic            w_ge;
    logic [XLEN-1:0] w_sub;
    logic [XLEN-1:0] w_hi_nxt, w_lo_nxt;

    assign w_run = (r_cnt != CNT_END);
    assign done  = w_run && (r_cnt == CNT_LAST);
    assign hi    = r_hi;
    assign lo    = r_lo;

    assign {w_carry, w_sum} = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_b : '0)};
    assign w_rem_sh = {r_hi, r_lo[XLEN-1]};
    assign w_ge     = (w_rem_sh >= {1'b0, r_b});
    // A successful trial subtraction always leaves a remainder below the divisor.
    assign w_sub    = w_rem_sh[XLEN-1:0] - r_b;

    always_comb begin
        w_hi_nxt = r_hi;
        w_lo_nxt = r_lo;
        if (r_is_div) begin
            w_hi_nxt = w_ge ? w_sub : w_rem_sh[XLEN-1:0];
            w_lo_nxt = {r_lo[XLEN-2:0], w_ge};
        end else begin
            w_hi_nxt = {w_carry, w_sum[XLEN-1:1]};
            w_lo_nxt = {w_sum[0], r_lo[XLEN-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
            r_is_div <= 1'b0;
            r_cnt    <= CNT_END;
        end else if (start) begin
            r_hi     <= '0;
            r_lo     <= a;
            r_b      <= b;
            r_is_div <= is_div(op);
            r_cnt    <= '0;
        end else if (w_run) begin
            r_hi  <= w_hi_nxt;
            r_lo  <= w_lo_nxt;
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/alu_mdu_seq.sv
// EX-stage ALU with RV-M multiply/divide behind valid/ready handshakes.
// Define FAST_MUL_EN to compute MUL* in one cycle with a full multiplier.
module alu_mdu_seq
    import alu_mdu_seq_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      alu_op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] res,
    output logic            zero,
    output logic            busy
);
    localparam int unsigned SHW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN - 1){1'b0}}};

    typedef enum logic [2:0] {StIdle, StMul, StDiv, StFix, StDone} state_e;

    state_e          r_state, w_state_nxt;
    logic [XLEN-1:0] r_res, w_res_nxt;
    logic [4:0]      r_op;
    logic            r_neg, r_neg_r;

    logic [SHW-1:0]  w_shamt;
    logic [XLEN-1:0] w_base, w_sp_res, w_imm_res, w_fix_res;
    logic [XLEN-1:0] w_a_mag, w_b_mag, w_hi, w_lo, w_quo, w_rem;
    logic [2*XLEN-1:0] w_prod_s;
    logic            w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;
    logic            w_div0, w_ovf, w_div_sp, w_fast, w_accept, w_start, w_done;

    assign out_valid = (r_state == StDone);
    assign busy      = (r_state == StMul) || (r_state == StDiv) || (r_state == StFix);
    assign in_ready  = (r_state == StIdle) || (out_valid && out_ready);
    assign res       = r_res;
    assign zero      = (r_res == '0);

    assign w_shamt = b[SHW-1:0];
    always_comb begin
        w_base = '0;
        case (alu_op)
            OP_ADD:  w_base = a + b;
            OP_SUB:  w_base = a - b;
            OP_SLL:  w_base = a << w_shamt;
            OP_SLT:  w_base = {{(XLEN - 1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: w_base = {{(XLEN - 1){1'b0}}, (a < b)};
            OP_XOR:  w_base = a ^ b;
            OP_SRL:  w_base = a >> w_shamt;
            OP_SRA:  w_base = $unsigned($signed(a) >>> w_shamt);
            OP_OR:   w_base = a | b;
            OP_AND:  w_base = a & b;
            default: w_base = '0;
        endcase
    end

    // Divide special cases complete without starting the engine.
    assign w_div0   = (b == '0);
    assign w_ovf    = (a == MIN_NEG) && (b == '1) && ((alu_op == OP_DIV) || (alu_op == OP_REM));
    assign w_div_sp = is_div(alu_op) && (w_div0 || w_ovf);
    always_comb begin
        w_sp_res = '0;
        if (w_div0) begin
            w_sp_res = ((alu_op == OP_DIV) || (alu_op == OP_DIVU)) ? '1 : a;
        end else begin
            w_sp_res = (alu_op == OP_DIV) ? a : '0;
        end
    end

    assign w_a_sgn = alu_op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    assign w_b_sgn = alu_op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    assign w_a_neg = w_a_sgn && a[XLEN-1];
    assign w_b_neg = w_b_sgn && b[XLEN-1];
    assign w_a_mag = w_a_neg ? -a : a;
    assign w_b_mag = w_b_neg ? -b : b;

`ifdef FAST_MUL_EN
    logic [2*XLEN-1:0] w_ax, w_bx, w_fm;
    assign w_fast = is_mul(alu_op);
    assign w_ax   = {{XLEN{w_a_neg}}, a};
    assign w_bx   = {{XLEN{w_b_neg}}, b};
    assign w_fm   = w_ax * w_bx;
    assign w_imm_res = w_fast ? ((alu_op == OP_MUL) ? w_fm[XLEN-1:0] : w_fm[2*XLEN-1:XLEN]) :
                       w_div_sp ? w_sp_res : w_base;
`else
    assign w_fast    = 1'b0;
    assign w_imm_res = w_div_sp ? w_sp_res : w_base;
`endif

    assign w_accept = in_valid && in_ready && !flush;
    assign w_start  = w_accept && is_muldiv(alu_op) && !w_fast && !w_div_sp;

    mdu_iter #(
        .XLEN(XLEN)
    ) u_mdu_iter (
        .clk   (clk),
        .rst_n (rst_n),
        .start (w_start),
        .op    (alu_op),
        .a     (w_a_mag),
        .b     (w_b_mag),
        .done  (w_done),
        .hi    (w_hi),
        .lo    (w_lo)
    );

    // Engine works on magnitudes; restore signs and pick the requested half.
    assign w_prod_s = r_neg ? -{w_hi, w_lo} : {w_hi, w_lo};
    assign w_quo    = r_neg ? -w_lo : w_lo;
    assign w_rem    = r_neg_r ? -w_hi : w_hi;
    always_comb begin
        w_fix_res = '0;
        case (r_op)
            OP_MUL:                        w_fix_res = w_prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  w_fix_res = w_prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               w_fix_res = w_quo;
            OP_REM, OP_REMU:               w_fix_res = w_rem;
            default:                       w_fix_res = '0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_res_nxt   = r_res;
        if (flush) begin
            w_state_nxt = StIdle;
        end else begin
            case (r_state)
                StMul, StDiv: if (w_done) w_state_nxt = StFix;
                StFix: begin
                    w_state_nxt = StDone;
                    w_res_nxt   = w_fix_res;
                end
                StDone:  if (out_ready) w_state_nxt = StIdle;
                default: w_state_nxt = r_state;
            endcase
            if (w_accept) begin
                if (w_start) begin
                    w_state_nxt = is_div(alu_op) ? StDiv : StMul;
                end else begin
                    w_state_nxt = StDone;
                    w_res_nxt   = w_imm_res;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_res   <= '0;
            r_op    <= OP_ADD;
            r_neg   <= 1'b0;
            r_neg_r <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_res   <= w_res_nxt;
            if (w_start) begin
                r_op    <= alu_op;
                r_neg   <= w_a_neg ^ w_b_neg;
                r_neg_r <= w_a_neg;
            end
        end
    end

endmodule

// File: tb/tb_alu_mdu_seq.sv
// Randomised scoreboard bench for alu_mdu_seq; honours FAST_MUL_EN for expected latencies.
module tb_alu_mdu_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [4:0]  alu_op = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] res;
    logic        zero;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit rdy_rand = 1'b0;

    typedef struct {
        logic [31:0] res;
        int          acc;
        int          lat;
        bit          seen;
    } exp_t;
    exp_t q[$];

    alu_mdu_seq #(
        .XLEN(32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .alu_op    (alu_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .zero      (zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] x,
                                          input logic [31:0] y);
        longint      sx = longint'($signed(x));
        longint      sy = longint'($signed(y));
        longint      uy = longint'({32'b0, y});
        logic [4:0]  sh = y[4:0];
        logic [63:0] p;
        bit          ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        case (op)
            5'd0:  return x + y;
            5'd1:  return x - y;
            5'd2:  return x << sh;
            5'd3:  return (sx < sy) ? 32'd1 : 32'd0;
            5'd4:  return (x < y) ? 32'd1 : 32'd0;
            5'd5:  return x ^ y;
            5'd6:  return x >> sh;
            5'd7:  return 32'($signed(x) >>> sh);
            5'd8:  return x | y;
            5'd9:  return x & y;
            5'd16: begin p = 64'(sx * sy); return p[31:0]; end
            5'd17: begin p = 64'(sx * sy); return p[63:32]; end
            5'd18: begin p = 64'(sx * uy); return p[63:32]; end
            5'd19: begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
            5'd20: return (y == 0) ? 32'hFFFF_FFFF : ovf ? x : 32'(sx / sy);
            5'd21: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            5'd22: return (y == 0) ? x : ovf ? 32'd0 : 32'(sx % sy);
            5'd23: return (y == 0) ? x : x % y;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int lat_of(input logic [4:0] op, input logic [31:0] x,
                                  input logic [31:0] y);
        bit ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        if (op >= 5'd16 && op <= 5'd19) begin
`ifdef FAST_MUL_EN
            return 1;
`else
            return 34;
`endif
        end
        if (op >= 5'd20 && op <= 5'd23) begin
            if (y == 0 || (ovf && (op == 5'd20 || op == 5'd22))) return 1;
            return 34;
        end
        return 1;
    endfunction

    // Scoreboard: every cycle outside reset.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready_rule", {63'b0, in_ready},
                {63'b0, (!busy && !out_valid) || (out_valid && out_ready)});
            if (out_valid) begin
                chk("busy_when_valid", {63'b0, busy}, 64'd0);
                if (q.size() == 0) begin
                    chk("spurious_out_valid", {63'b0, out_valid}, 64'd0);
                end else begin
                    chk("res", {32'b0, res}, {32'b0, q[0].res});
                    chk("zero", {63'b0, zero}, {63'b0, q[0].res == 0});
                    if (!q[0].seen) begin
                        chk("latency", 64'(cyc - q[0].acc), 64'(q[0].lat));
                        q[0].seen = 1'b1;
                    end
                    if (out_ready) void'(q.pop_front());
                end
            end else begin
                chk("busy", {63'b0, busy}, {63'b0, q.size() > 0 && !q[0].seen &&
                                              q[0].lat > 1 && cyc > q[0].acc});
                if (q.size() > 0 && !q[0].seen && cyc >= q[0].acc + q[0].lat) begin
                    chk("latency_late", 64'(cyc - q[0].acc), 64'(q[0].lat));
                    q[0].seen = 1'b1;
                end
            end
        end
    end

    // Present an op until accepted; rdy >= 0 also drives out_ready in the same cycle.
    task automatic issue(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y,
                         input int rdy);
        exp_t e;
        int   waited = 0;
        bit   acc = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        alu_op   = op;
        a        = x;
        b        = y;
        if (rdy >= 0) out_ready = (rdy != 0);
        while (!acc) begin
            @(negedge clk);
            if (in_ready) begin
                acc   = 1'b1;
                e.res = model(op, x, y);
                e.acc = cyc;
                e.lat = lat_of(op, x, y);
                e.seen = 1'b0;
                q.push_back(e);
            end else if (waited > 100) begin
                chk("accept_timeout", 64'd0, 64'd1);
                acc = 1'b1;
            end else begin
                waited++;
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        idle_cycle();
        while (q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            chk("drain_timeout", 64'(q.size()), 64'd0);
            q.delete();
        end
    endtask

    task automatic wait_valid();
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("wait_valid", {63'b0, out_valid}, 64'd1);
    endtask

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0]  op;
        logic [31:0] x, y;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_res", {32'b0, res}, 64'd0);
        chk("rst_zero", {63'b0, zero}, 64'd1);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_in_ready", {63'b0, in_ready}, 64'd1);

        // Pin the reference model with hand-computed values.
        chk("pin_add", {32'b0, model(5'd0, 32'h7FFF_FFFF, 32'd1)}, 64'h8000_0000);
        chk("pin_sra", {32'b0, model(5'd7, 32'h8000_0000, 32'd33)}, 64'hC000_0000);
        chk("pin_sltu", {32'b0, model(5'd4, 32'd1, 32'hFFFF_FFFF)}, 64'd1);
        chk("pin_slt", {32'b0, model(5'd3, 32'd1, 32'hFFFF_FFFF)}, 64'd0);
        chk("pin_mulh", {32'b0, model(5'd17, 32'h8000_0000, 32'h8000_0000)}, 64'h4000_0000);
        chk("pin_mulhsu", {32'b0, model(5'd18, 32'hFFFF_FFFF, 32'hFFFF_FFFF)}, 64'hFFFF_FFFF);
        chk("pin_div0", {32'b0, model(5'd20, 32'd7, 32'd0)}, 64'hFFFF_FFFF);
        chk("pin_rem0", {32'b0, model(5'd22, 32'd7, 32'd0)}, 64'd7);
        chk("pin_divovf", {32'b0, model(5'd20, 32'h8000_0000, 32'hFFFF_FFFF)}, 64'h8000_0000);
        chk("pin_divu", {32'b0, model(5'd21, 32'd100, 32'd7)}, 64'd14);
        chk("pin_rem_neg", {32'b0, model(5'd22, 32'hFFFF_FFF9, 32'd2)}, 64'hFFFF_FFFF);
        chk("pin_div_neg", {32'b0, model(5'd20, 32'hFFFF_FFF9, 32'd2)}, 64'hFFFF_FFFD);

        // Directed corner cases through the scoreboard.
        issue(5'd0, 32'h7FFF_FFFF, 32'd1, 1);
        issue(5'd7, 32'h8000_0000, 32'd33, 1);
        issue(5'd4, 32'd1, 32'hFFFF_FFFF, 1);
        issue(5'd17, 32'h8000_0000, 32'h8000_0000, 1);
        issue(5'd20, 32'd7, 32'd0, 1);
        issue(5'd22, 32'd7, 32'd0, 1);
        issue(5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        issue(5'd12, 32'd5, 32'd6, 1);
        drain();

        // Hold the DIVU result, then release and accept ADD in the same cycle.
        issue(5'd21, 32'd100, 32'd7, 0);
        idle_cycle();
        wait_valid();
        repeat (4) begin
            @(negedge clk);
            chk("hold_in_ready", {63'b0, in_ready}, 64'd0);
            chk("hold_res", {32'b0, res}, 64'd14);
        end
        issue(5'd0, 32'd5, 32'd6, 1);
        drain();

        // Flush a REM mid-flight; in_valid during the flush cycle is ignored.
        issue(5'd22, 32'hFFFF_FFF9, 32'd2, 1);
        idle_cycle();
        repeat (8) @(posedge clk);
        @(posedge clk);
        #1;
        flush = 1'b1;
        in_valid = 1'b1;
        alu_op = 5'd0;
        a = 32'd1;
        b = 32'd2;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        q.delete();
        @(negedge clk);
        chk("flush_out_valid", {63'b0, out_valid}, 64'd0);
        chk("flush_in_ready", {63'b0, in_ready}, 64'd1);
        chk("flush_busy", {63'b0, busy}, 64'd0);
        issue(5'd0, 32'd40, 32'd2, 1);
        drain();

        // Asynchronous reset mid-DIV.
        issue(5'd20, 32'd1000, 32'd3, 1);
        idle_cycle();
        repeat (4) @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("arst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("arst_res", {32'b0, res}, 64'd0);
        chk("arst_zero", {63'b0, zero}, 64'd1);
        chk("arst_busy", {63'b0, busy}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_in_ready", {63'b0, in_ready}, 64'd1);
        chk("arst_no_valid", {63'b0, out_valid}, 64'd0);
        issue(5'd0, 32'hFFFF_FFFF, 32'd1, 1);
        drain();

        // Randomised traffic with random back-pressure.
        rdy_rand = 1'b1;
        for (int i = 0; i < 300; i++) begin
            x = rand_val();
            y = rand_val();
            case ($urandom_range(0, 9))
                0, 1, 2, 3: op = 5'($urandom_range(0, 9));
                4, 5, 6, 7: op = 5'($urandom_range(16, 23));
                8:          op = 5'($urandom_range(0, 31));
                default: begin
                    op = ($urandom_range(0, 1) != 0) ? 5'd20 : 5'd22;
                    if ($urandom_range(0, 1) != 0) begin
                        y = 32'd0;
                    end else begin
                        x = 32'h8000_0000;
                        y = 32'hFFFF_FFFF;
                    end
                end
            endcase
            issue(op, x, y, -1);
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end
        drain();
        rdy_rand = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
